// File: rtl/bus_pkg.sv
// Shared types and helpers for the serial frame receiver.
// Line levels, receiver state encoding, frame length clamp.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    RECOVER
  } rx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam int   CNT_W      = 4;

  // Zero or oversize requests fall back to the full port width.
  function automatic logic [CNT_W-1:0] eff_len(
    input logic [CNT_W-1:0] bit_lngt,
    input int               width
  );
    logic [CNT_W-1:0] w;
    w = CNT_W'(width);
    if (bit_lngt == '0 || bit_lngt > w)
      return w;
    return bit_lngt;
  endfunction

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Receive-side bus bundle: control/serial inputs and word outputs.
// master drives the line, slave is the receiver.
interface serial_frame_receiver_if #(
  parameter int parellel_port_width = 14
);

  logic                           rx_en;
  logic [3:0]                     bit_lngt;
  logic                           serial_in;
  logic [parellel_port_width-1:0] parellel_out;
  logic                           dv_out;
  logic                           busy;
  logic                           frame_err;
  logic                           parity_err;

  modport master (
    output rx_en,
    output bit_lngt,
    output serial_in,
    input  parellel_out,
    input  dv_out,
    input  busy,
    input  frame_err,
    input  parity_err
  );

  modport slave (
    input  rx_en,
    input  bit_lngt,
    input  serial_in,
    output parellel_out,
    output dv_out,
    output busy,
    output frame_err,
    output parity_err
  );

endinterface

// File: rtl/serial_shift_in.sv
// MSB-first shift register with a down-counter of remaining bits.
// last_o flags that the current shift consumes the final data bit.
module serial_shift_in
  import bus_pkg::*;
#(
  parameter int W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             bit_i,
  output logic [W-1:0]     data_o,
  output logic             last_o
);

  logic [W-1:0]     data_q;
  logic [W-1:0]     data_d;
  logic [CNT_W-1:0] cnt_q;

  // New bit enters at the LSB so the first bit ends up as the MSB.
  always_comb begin
    data_d    = data_q << 1;
    data_d[0] = bit_i;
  end

  // Clear on start detection, shift and count down per data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      data_q <= '0;
      cnt_q  <= len_i;
    end else if (shift_i) begin
      data_q <= data_d;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  assign data_o = data_q;
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start, N data bits MSB first, stop.
// Define PARITY_CHECK_EN to add an even-parity bit after data.
module serial_frame_receiver
  import bus_pkg::*;
#(
  parameter int parellel_port_width = 14
) (
  input  logic                  clk,
  input  logic                  rstn,
  serial_frame_receiver_if.slave bus
);

  localparam int W = parellel_port_width;

  rx_state_e        state_q;
  logic             busy_q;
  logic             dv_q;
  logic             ferr_q;
  logic [W-1:0]     pout_q;
  logic [W-1:0]     shreg;
  logic             last_bit;
  logic             clr;
  logic             shift;
  logic [CNT_W-1:0] len;

  assign len   = eff_len(bus.bit_lngt, W);
  assign clr   = (state_q == IDLE) && bus.rx_en
               && (bus.serial_in == LINE_START);
  assign shift = (state_q == DATA) && bus.rx_en;

  serial_shift_in #(
    .W (W)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rstn),
    .clr_i   (clr),
    .shift_i (shift),
    .len_i   (len),
    .bit_i   (bus.serial_in),
    .data_o  (shreg),
    .last_o  (last_bit)
  );

`ifdef PARITY_CHECK_EN
  logic perr_q;
  logic par_ok;

  assign par_ok = ((^shreg) ^ bus.serial_in) == 1'b0;
`endif

  // Frame FSM with registered strobes, busy and output word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      pout_q  <= '0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q <= 1'b0;
`endif
      if (!bus.rx_en) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.serial_in == LINE_START) begin
              state_q <= DATA;
              busy_q  <= 1'b1;
            end
          end
          DATA: begin
            if (last_bit) begin
`ifdef PARITY_CHECK_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
          PARITY: begin
`ifdef PARITY_CHECK_EN
            if (par_ok) begin
              state_q <= STOP;
            end else begin
              perr_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= RECOVER;
            end
`else
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end
          STOP: begin
            busy_q <= 1'b0;
            if (bus.serial_in == LINE_IDLE) begin
              pout_q  <= shreg;
              dv_q    <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= RECOVER;
            end
          end
          RECOVER: begin
            if (bus.serial_in == LINE_IDLE)
              state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.parellel_out = pout_q;
  assign bus.dv_out       = dv_q;
  assign bus.busy         = busy_q;
  assign bus.frame_err    = ferr_q;
`ifdef PARITY_CHECK_EN
  assign bus.parity_err   = perr_q;
`else
  assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver.
// Expected words are queued at the start bit and popped on dv_out.
module tb_serial_frame_receiver;

  typedef struct {
    logic [13:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dv_cnt = 0;
  int   ferr_cnt = 0;
  int   perr_cnt = 0;
  int   busy_cnt = 0;
  logic prev_strobe = 1'b0;
  exp_t q[$];

  serial_frame_receiver_if #(.parellel_port_width(14)) bus ();

  serial_frame_receiver #(
    .parellel_port_width (14)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: strobe sanity and scoreboard comparison.
  always @(negedge clk) begin
    int   ns;
    exp_t e;
    ns = int'(bus.dv_out) + int'(bus.frame_err) + int'(bus.parity_err);
    if (bus.busy) busy_cnt++;
    if (bus.frame_err) ferr_cnt++;
    if (bus.parity_err) perr_cnt++;
    if (ns != 0) begin
      checks++;
      if (ns > 1 || prev_strobe) begin
        errors++;
        $display("FAIL strobe_excl: count %0d prev %0b want single", ns, prev_strobe);
      end
    end
    prev_strobe = (ns != 0);
    if (bus.dv_out) begin
      dv_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dv: got %h at cyc %0d want none", bus.parellel_out, cyc);
      end else begin
        e = q.pop_front();
        if (bus.parellel_out !== e.data || cyc !== e.cyc) begin
          errors++;
          $display("FAIL sb_word: got %h @%0d want %h @%0d", bus.parellel_out, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.serial_in = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [14:0] data, input int n, input logic stop,
                            input bit use_par, input logic par_bit, input bit good);
    exp_t e;
    @(negedge clk);
    bus.serial_in = 1'b0;
    if (good) begin
      e.data = data[13:0];
      e.cyc  = cyc + 1 + n + 1 + (use_par ? 1 : 0);
      q.push_back(e);
    end
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      bus.serial_in = data[i];
    end
    if (use_par) begin
      @(negedge clk);
      bus.serial_in = par_bit;
    end
    @(negedge clk);
    bus.serial_in = stop;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 60) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending want 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    bus.rx_en = 1'b1;
    bus.bit_lngt = 4'd8;
    bus.serial_in = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.parellel_out !== 14'h0 || bus.dv_out !== 1'b0 || bus.busy !== 1'b0
        || bus.frame_err !== 1'b0 || bus.parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: got %h/%b/%b/%b/%b want 0", bus.parellel_out,
               bus.dv_out, bus.busy, bus.frame_err, bus.parity_err);
    end
    rstn = 1'b1;
    idle(3);
  endtask

  task automatic test_good8();
    int d0 = dv_cnt;
    int b0 = busy_cnt;
    bus.bit_lngt = 4'd8;
    send_frame(15'h0A5, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    drain("good8");
    checks++;
    if (dv_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL good8_dv: got %0d want 1", dv_cnt - d0);
    end
    checks++;
    if (busy_cnt - b0 !== 9) begin
      errors++;
      $display("FAIL good8_busy: got %0d want 9", busy_cnt - b0);
    end
    checks++;
    if (bus.parellel_out !== 14'h00A5) begin
      errors++;
      $display("FAIL good8_word: got %h want 00a5", bus.parellel_out);
    end
  endtask

  task automatic test_full_width();
    int d0 = dv_cnt;
    bus.bit_lngt = 4'd0;
    send_frame(15'h2A5C, 14, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    bus.bit_lngt = 4'd15;
    send_frame(15'h2A5C, 14, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    drain("full");
    checks++;
    if (dv_cnt - d0 !== 2 || bus.parellel_out !== 14'h2A5C) begin
      errors++;
      $display("FAIL full_word: got %0d/%h want 2/2a5c", dv_cnt - d0, bus.parellel_out);
    end
  endtask

  task automatic test_frame_err();
    int d0 = dv_cnt;
    int f0 = ferr_cnt;
    bus.bit_lngt = 4'd8;
    send_frame(15'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL ferr_recover_busy%0d: got %b want 0", i, bus.busy);
      end
      bus.serial_in = (i == 3) ? 1'b1 : 1'b0;
    end
    idle(3);
    checks++;
    if (ferr_cnt - f0 !== 1 || dv_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL ferr_strobes: got %0d/%0d want 1/0", ferr_cnt - f0, dv_cnt - d0);
    end
    checks++;
    if (bus.parellel_out !== 14'h2A5C) begin
      errors++;
      $display("FAIL ferr_hold: got %h want 2a5c", bus.parellel_out);
    end
  endtask

  task automatic test_abort_reset();
    int d0 = dv_cnt;
    int f0 = ferr_cnt;
    logic [7:0] v = 8'hA5;
    bus.bit_lngt = 4'd8;
    @(negedge clk);
    bus.serial_in = 1'b0;
    for (int i = 7; i > 3; i--) begin
      @(negedge clk);
      bus.serial_in = v[i];
    end
    @(negedge clk);
    bus.rx_en = 1'b0;
    bus.serial_in = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b want 0", bus.busy);
    end
    idle(12);
    bus.rx_en = 1'b1;
    idle(14);
    checks++;
    if (dv_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin
      errors++;
      $display("FAIL abort_strobes: got %0d/%0d want 0/0", dv_cnt - d0, ferr_cnt - f0);
    end
    @(negedge clk);
    bus.serial_in = 1'b0;
    for (int i = 7; i > 4; i--) begin
      @(negedge clk);
      bus.serial_in = v[i];
    end
    @(negedge clk);
    rstn = 1'b0;
    bus.serial_in = 1'b1;
    #1;
    checks++;
    if (bus.parellel_out !== 14'h0 || bus.busy !== 1'b0 || bus.dv_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outs: got %h/%b/%b want 0", bus.parellel_out, bus.busy, bus.dv_out);
    end
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
    send_frame(15'h012, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    drain("after_reset");
    checks++;
    if (bus.parellel_out !== 14'h0012) begin
      errors++;
      $display("FAIL after_reset_word: got %h want 0012", bus.parellel_out);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = dv_cnt;
    bus.bit_lngt = 4'd4;
    send_frame(15'h9, 4, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    send_frame(15'h6, 4, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    drain("b2b_gap");
    checks++;
    if (dv_cnt - d0 !== 2 || bus.parellel_out !== 14'h0006) begin
      errors++;
      $display("FAIL b2b_gap: got %0d/%h want 2/0006", dv_cnt - d0, bus.parellel_out);
    end
    d0 = dv_cnt;
    send_frame(15'h9, 4, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(15'h6, 4, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    drain("b2b_tight");
    checks++;
    if (dv_cnt - d0 !== 2 || bus.parellel_out !== 14'h0006) begin
      errors++;
      $display("FAIL b2b_tight: got %0d/%h want 2/0006", dv_cnt - d0, bus.parellel_out);
    end
  endtask

  task automatic test_parity();
    int d0 = dv_cnt;
    int p0 = perr_cnt;
    bus.bit_lngt = 4'd8;
`ifdef PARITY_CHECK_EN
    send_frame(15'h0A5, 8, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);
    drain("par_good");
    send_frame(15'h0A5, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    checks++;
    if (dv_cnt - d0 !== 1 || perr_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL parity: got %0d/%0d want 1/1", dv_cnt - d0, perr_cnt - p0);
    end
`else
    send_frame(15'h0A4, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    drain("nopar");
    checks++;
    if (perr_cnt !== 0 || dv_cnt - d0 !== 1 || bus.parellel_out !== 14'h00A4) begin
      errors++;
      $display("FAIL nopar: got %0d/%0d/%h want 0/1/00a4", perr_cnt, dv_cnt - d0, bus.parellel_out);
    end
`endif
    checks++;
    if (p0 > perr_cnt) begin
      errors++;
      $display("FAIL parity_count: got %0d want >= %0d", perr_cnt, p0);
    end
  endtask

  initial begin
    test_reset();
    test_good8();
    test_full_width();
    test_frame_err();
    test_abort_reset();
    test_back_to_back();
    test_parity();
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
Dedicated serial-to-parallel receiver for the bus serial line. It is the receiving end for frames shifted out by the bidirectional converter in parallel-to-serial mode. It detects a start bit, shifts in a programmable number of data bits (MSB first, one bit per clk), checks the stop bit, and presents the word right-aligned with a one-cycle valid strobe. It sits in every master/slave bus interface that only needs to listen.

Parameters:
parellel_port_width, 14, width of parellel_out and the maximum frame data length (legal range 1..15).

Ports:
clk  input  1  system clock; all logic on rising edge
rstn  input  1  asynchronous active-low reset
rx_en  input  1  receive enable; low forces IDLE / aborts a frame
bit_lngt  input  4  requested data-bit count N; sampled only at start-bit detection
serial_in  input  1  serial line; idle level 1
parellel_out  output  parellel_port_width  last good word, right-aligned, upper bits 0
dv_out  output  1  one-cycle strobe: parellel_out updated this cycle
busy  output  1  high in DATA, STOP and PARITY states
frame_err  output  1  one-cycle strobe: stop bit sampled 0
parity_err  output  1  one-cycle strobe: parity mismatch (tied 0 without macro)

Behaviour:
- Reset: asynchronous, active-low. All outputs 0, state IDLE, shift register 0, bit counter 0. Reset mid-frame discards the partial word.
- Effective length: N_eff = parellel_port_width if bit_lngt == 0 or bit_lngt > parellel_port_width; otherwise N_eff = bit_lngt. N_eff is latched on the start edge.
- IDLE: if rx_en && serial_in == 0 at edge k (start bit), clear the shift register, load counter = N_eff, and go to DATA.
- DATA: edges k+1 .. k+N_eff each shift in serial_in (shreg <= {shreg, serial_in}, so the first bit received is the MSB) and decrement the counter. On the last bit, go to STOP (or PARITY with the macro).
- STOP at edge k+N_eff+1:
  - serial_in == 1: parellel_out <= shreg with upper (width − N_eff) bits zero; dv_out = 1 for exactly one cycle; go to IDLE.
  - serial_in == 0: frame_err = 1 for one cycle; parellel_out unchanged; go to RECOVER.
- RECOVER: wait for serial_in == 1, then go to IDLE. This prevents a stuck-low line from being taken as a new start.
- Back-to-back frames: a start bit may be detected in the cycle immediately after a good stop bit (the IDLE cycle). No dead time is required beyond that one cycle.
- rx_en low in any state: next state IDLE, no dv_out, no error strobes. parellel_out holds its value.
- Latency: start edge k → dv_out high in the cycle after edge k+N_eff+1 (k+N_eff+2 with parity).
- dv_out, frame_err and parity_err are mutually exclusive and never high two consecutive cycles from the same frame.
- busy is registered and follows the state: 1 from the cycle after the start edge until the return to IDLE/RECOVER.

Optional Feature:
PARITY_CHECK_EN
- Defined: a PARITY state is inserted after DATA. One extra bit is sampled and must make even parity over the N_eff data bits plus the parity bit. On mismatch, parity_err pulses one cycle, the word is discarded and the FSM goes to RECOVER without sampling a stop bit. On a match, the FSM proceeds to STOP as normal.
- Undefined: no PARITY state, frame = start + data + stop, parity_err is constant 0.

Decomposition:
- Shared package (bus_pkg):
  - rx state enum {IDLE, DATA, PARITY, STOP, RECOVER}
  - constants LINE_IDLE = 1'b1, LINE_START = 1'b0
  - function eff_len(bit_lngt, width)
- Sub-module serial_shift_in: clear/shift-enable shift register plus down-counter with a last_bit flag. The FSM stays in serial_frame_receiver.

Test Plan:
1. Good 8-bit frame. bit_lngt = 8, rx_en = 1; serial_in = 0, 1,0,1,0,0,1,0,1, 1 (start, 0xA5 MSB first, stop) → parellel_out = 14'h00A5, dv_out high one cycle 10 cycles after the start edge, busy high 9 cycles.
2. Full-width frame. bit_lngt = 0, frame carries 14'h2A5C → parellel_out = 14'h2A5C, dv_out after 15 edges. Repeat with bit_lngt = 15 → identical result.
3. Framing error. 8-bit frame with 0x3C and stop = 0, line held low 3 more cycles then high → frame_err one cycle, no dv_out, parellel_out keeps its previous value, no new frame until the line returns high.
4. Abort and reset. rx_en dropped after 4 data bits → IDLE, no strobes. Repeat with rstn asserted mid-frame → all outputs 0 immediately. A following clean frame 0x12 is received correctly.
5. Back-to-back. Two 4-bit frames 0x9 and 0x6 with a single idle-high cycle between them → two dv_out pulses, parellel_out = 14'h0009 then 14'h0006.
6. Parity (PARITY_CHECK_EN defined). 8-bit 0xA5 with parity bit 0 → dv_out. Same frame with parity bit 1 → parity_err pulse, no dv_out.
